instr_issue_fifo: RTL and testbench

//  Buffers host-written 24-bit instructions ({opcode[23:20], op1[19:10], op2[9:0]}) and issues them one per cycle to the

---
 rtl/instr_issue_fifo.sv | 133 +++++++++++++
 tb/tb_instr_issue_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_fifo.sv
// Instruction issue FIFO: buffers host instructions and issues them
// one per cycle to the decoder, stalling after MV_MUL until mvm_done.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push_valid/push_instr   host enqueue request and data
//   push_ready              FIFO not full
//   start_chain             begin issuing (honoured in IDLE only)
//   mvm_done                outstanding MV_MUL complete
//   instr_out/instr_valid   registered instruction to decoder
//   chain_done              pulse with the issued END_CHAIN
//   busy                    FSM not IDLE
//   fifo_count              entries held (0..DEPTH)
//   overflow                sticky: push attempted while full
module instr_issue_fifo #(
  parameter int INSTR_WIDTH  = 24,
  parameter int OPCODE_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic                   push_ready,
  input  logic                   start_chain,
  input  logic                   mvm_done,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   chain_done,
  output logic                   busy,
  output logic [ADDR_W:0]        fifo_count,
  output logic                   overflow
);

  localparam logic [INSTR_WIDTH-1:0] NOP =
    INSTR_WIDTH'(24'h700000);
  localparam logic [OPCODE_WIDTH-1:0] OP_MV_MUL =
    OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_END =
    OPCODE_WIDTH'(12);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_MVM
  } state_t;

  state_t                  state;
  logic [INSTR_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic                    push_acc;
  logic                    pop;
  logic [INSTR_WIDTH-1:0]  head;
  logic [OPCODE_WIDTH-1:0] head_op;

  assign push_ready = (fifo_count != FULL);
  assign push_acc   = push_valid & push_ready;
  // Count is registered, so a word pushed into an empty
  // FIFO only becomes poppable on the following cycle.
  assign pop     = (state == ISSUE) && (fifo_count != '0);
  assign head    = mem[rd_ptr];
  assign head_op = head[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      instr_out   <= NOP;
      instr_valid <= 1'b0;
      chain_done  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_acc && !pop) begin
        fifo_count <= fifo_count + (ADDR_W+1)'(1);
      end else if (pop && !push_acc) begin
        fifo_count <= fifo_count - (ADDR_W+1)'(1);
      end
      if (push_valid && !push_ready) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        instr_out   <= head;
        instr_valid <= 1'b1;
        chain_done  <= (head_op == OP_END);
      end else begin
        instr_out   <= NOP;
        instr_valid <= 1'b0;
        chain_done  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start_chain) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (pop && head_op == OP_MV_MUL) begin
            state <= WAIT_MVM;
          end else if (pop && head_op == OP_END) begin
            state <= IDLE;
          end
        end
        WAIT_MVM: begin
          if (mvm_done) begin
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_fifo.sv
// Testbench for instr_issue_fifo: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_instr_issue_fifo;

  localparam logic [23:0] NOP = 24'h700000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_valid = 1'b0;
  logic [23:0] push_instr = '0;
  logic        push_ready;
  logic        start_chain = 1'b0;
  logic        mvm_done = 1'b0;
  logic [23:0] instr_out;
  logic        instr_valid;
  logic        chain_done;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  instr_issue_fifo dut (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_instr(push_instr),
    .push_ready(push_ready),
    .start_chain(start_chain),
    .mvm_done(mvm_done),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .chain_done(chain_done),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a queue plus "running / waiting" flags.
  logic [23:0] q[$];
  bit          running = 0;
  bit          waiting = 0;
  bit          armed = 0;
  logic [23:0] m_out = NOP;
  bit          m_valid = 0;
  bit          m_cd = 0;
  bit          m_ovf = 0;
  logic [23:0] m_h;
  bit          m_take;
  bit          m_full;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      running = 0;
      waiting = 0;
      m_out   = NOP;
      m_valid = 0;
      m_cd    = 0;
      m_ovf   = 0;
      armed   = 1;
    end else begin
      m_full = (q.size() == 16);
      m_take = running && !waiting && (q.size() != 0);
      m_h    = m_take ? q[0] : NOP;
      if (m_take) void'(q.pop_front());
      if (push_valid && m_full) m_ovf = 1;
      if (push_valid && !m_full) q.push_back(push_instr);
      m_out   = m_h;
      m_valid = m_take;
      m_cd    = m_take && (m_h[23:20] == 4'd12);
      if (!running) begin
        if (start_chain) running = 1;
      end else if (waiting) begin
        if (mvm_done) waiting = 0;
      end else if (m_take) begin
        if (m_h[23:20] == 4'd4) waiting = 1;
        if (m_h[23:20] == 4'd12) running = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m_out", 32'(instr_out), 32'(m_out));
      check("m_valid", 32'(instr_valid), 32'(m_valid));
      check("m_cd", 32'(chain_done), 32'(m_cd));
      check("m_busy", 32'(busy), 32'(running));
      check("m_count", 32'(fifo_count), 32'(q.size()));
      check("m_ready", 32'(push_ready),
            32'(q.size() != 16));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push_valid = 1'b0;
    start_chain = 1'b0;
    mvm_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [23:0] w);
    push_valid = 1'b1;
    push_instr = w;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic start();
    start_chain = 1'b1;
    tick();
    start_chain = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      tick();
    end
    check(name, 32'(busy), 32'd0);
  endtask

  logic [23:0] t1 [3];

  initial begin
    t1[0] = 24'h100C05;
    t1[1] = 24'h501002;
    t1[2] = 24'hC00000;

    // 1: reset state, simple chain
    do_reset();
    check("rst_out", 32'(instr_out), 32'h700000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(push_ready), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) push(t1[i]);
    check("t1_count3", 32'(fifo_count), 32'd3);
    start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_out", 32'(instr_out), 32'(t1[i]));
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_cd", 32'(chain_done), 32'(i == 2));
    end
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_count0", 32'(fifo_count), 32'd0);

    // 2: MV_MUL stall until mvm_done
    do_reset();
    push(24'h400010);
    push(24'h803004);
    start();
    tick();
    check("t2_mv", 32'(instr_out), 32'h400010);
    check("t2_mv_v", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_stall", 32'(instr_out), 32'h700000);
      check("t2_stall_v", 32'(instr_valid), 32'd0);
    end
    mvm_done = 1'b1;
    tick();
    mvm_done = 1'b0;
    check("t2_done_nop", 32'(instr_valid), 32'd0);
    tick();
    check("t2_next", 32'(instr_out), 32'h803004);
    check("t2_next_v", 32'(instr_valid), 32'd1);

    // 3: overflow with 17 pushes, no start
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        check("t3_ready", 32'(push_ready), 32'd0);
        check("t3_count", 32'(fifo_count), 32'd16);
      end
      push(24'h100000 + 24'(i));
    end
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count2", 32'(fifo_count), 32'd16);

    // 5: issue from full FIFO with push_valid held
    start();
    for (int i = 0; i < 24; i++) begin
      push_valid = 1'b1;
      push_instr = {4'(13 + (i % 3)), 10'(i), 10'(i + 1)};
      tick();
      if (i == 0) begin
        check("t5_first", 32'(instr_out), 32'h100000);
      end
    end
    push_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    push(24'hC00001);
    wait_idle("t5_idle");
    check("t5_count", 32'(fifo_count), 32'd0);

    // 4: start on empty FIFO, late push
    do_reset();
    start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_nop", 32'(instr_out), 32'h700000);
    end
    push(24'hC01001);
    check("t4_nofall", 32'(instr_valid), 32'd0);
    tick();
    check("t4_out", 32'(instr_out), 32'hC01001);
    check("t4_cd", 32'(chain_done), 32'd1);

    // 6: reset during WAIT_MVM
    do_reset();
    push(24'h400001);
    for (int i = 0; i < 5; i++) push(24'h200000 + 24'(i));
    start();
    tick();
    check("t6_mv", 32'(instr_out), 32'h400001);
    check("t6_q5", 32'(fifo_count), 32'd5);
    do_reset();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_out", 32'(instr_out), 32'h700000);
    mvm_done = 1'b1;
    tick();
    mvm_done = 1'b0;
    tick();
    check("t6_ign_b", 32'(busy), 32'd0);
    check("t6_ign_v", 32'(instr_valid), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
